// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Constants and small helpers for the AES-256 key schedule. The forward
//   round-key generator and the inverse step both use them, so both see the
//   same Rcon table and word/byte conventions.
//   Contents:
//     quartet_kind_e  which transform a quartet's first word went through
//     ikg_state_e     states of the inverse key-step sequencer
//     rcon_byte()     Rcon MSB for index 0..7 (01,02,04,...,80)
//     rotword()       RotWord: rotate a word left by one byte
//     word_byte()     extract byte 0..3 of a word (0 = [31:24])
//     set_byte()      replace byte 0..3 of a word (0 = [31:24])
// ---------------------------------------------------------------------------
package aes_pkg;

  // AES-256 works on 8-word windows; quartets start at i%8==0 or i%8==4.
  localparam int AES256_NK = 8;
  localparam logic [2:0] QK_POS_ROT_RCON = 3'd0;
  localparam logic [2:0] QK_POS_SUB_ONLY = 3'd4;

  typedef enum logic {
    QK_SUB_ONLY = 1'b0,   // i%8==4: SubWord only
    QK_ROT_RCON = 1'b1    // i%8==0: SubWord(RotWord) ^ Rcon
  } quartet_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } ikg_state_e;

  function automatic logic [7:0] rcon_byte(input logic [2:0] idx);
    logic [7:0] r;
    case (idx)
      3'd0:    r = 8'h01;
      3'd1:    r = 8'h02;
      3'd2:    r = 8'h04;
      3'd3:    r = 8'h08;
      3'd4:    r = 8'h10;
      3'd5:    r = 8'h20;
      3'd6:    r = 8'h40;
      3'd7:    r = 8'h80;
      default: r = 8'h01;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rotword(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      2'd3:    r[7:0]   = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/invroundkeygen_1lane.sv
// ---------------------------------------------------------------------------
// invroundkeygen_1lane
//   One inverse AES-256 key-schedule step. From the window {w4..w11} it
//   recovers {w0..w3}, letting a decryption core walk round keys from last
//   to first. The T() transform needs four S-box lookups; they go one byte
//   at a time through an S-box shared with the core.
//     w3 = w11^w10, w2 = w10^w9, w1 = w9^w8, w0 = w8^T(w7)
//     T(w) = SubWord(RotWord(w))^Rcon  (use_rcon=1) | SubWord(w)  (use_rcon=0)
//   Parameter SBOX_LAT: edges between an sbox_in update and sampling
//   sbox_out (1 = combinational S-box, 2 = registered S-box, ...).
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     w4..w11              window words, sampled on an accepted start
//     rcon_idx_in          Rcon index of the quartet being undone (w8..w11)
//     use_rcon_in          1: w8 was an i%8==0 word, 0: i%8==4 word
//     start                request pulse, accepted only while not busy
//     w0..w3               recovered words, held until the next done
//     rcon_idx_out         Rcon index for the preceding quartet
//     use_rcon_out         use_rcon for the preceding quartet
//     busy                 operation in flight
//     done                 one-cycle pulse, all outputs valid
//     sbox_in / sbox_out   byte to / result from the shared S-box
// ---------------------------------------------------------------------------
module invroundkeygen_1lane
  import aes_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] w4,
  input  logic [31:0] w5,
  input  logic [31:0] w6,
  input  logic [31:0] w7,
  input  logic [31:0] w8,
  input  logic [31:0] w9,
  input  logic [31:0] w10,
  input  logic [31:0] w11,
  input  logic [2:0]  rcon_idx_in,
  input  logic        use_rcon_in,
  input  logic        start,
  output logic [31:0] w0,
  output logic [31:0] w1,
  output logic [31:0] w2,
  output logic [31:0] w3,
  output logic [2:0]  rcon_idx_out,
  output logic        use_rcon_out,
  output logic        busy,
  output logic        done,
  output logic [7:0]  sbox_in,
  input  logic [7:0]  sbox_out
);

  // Last value of the wait counter before CAPTURE; the WAIT state lasts
  // SBOX_LAT-1 cycles and is never entered when SBOX_LAT==1.
  localparam logic [7:0] WAIT_LAST = (SBOX_LAT > 1) ? 8'(SBOX_LAT - 2) : 8'd0;

  // w4..w6 do not enter the inverse step (w7 feeds T(), w8..w11 the XORs).
  logic [95:0] unused_window_s;
  assign unused_window_s = {w4, w5, w6};

  // Latched operands
  logic [31:0] w8_r, w9_r, w10_r, w11_r;
  logic [31:0] src_r;         // w7, already rotated when use_rcon
  logic [2:0]  rcon_idx_r;
  logic        use_rcon_r;

  // Sequencing
  ikg_state_e  state_r, state_s;
  logic [1:0]  byte_idx_r;
  logic [7:0]  wait_cnt_r;
  logic [31:0] sub_r;         // SubWord result, filled byte by byte

  // Registered outputs
  logic [31:0] w0_r, w1_r, w2_r, w3_r;
  logic [2:0]  rcon_idx_out_r;
  logic        use_rcon_out_r;
  logic        busy_r;
  logic        done_r;
  logic [7:0]  sbox_in_r;

  // Decoded strobes / datapath
  logic        accept_s, issue_s, capture_s, last_s, wait_done_s;
  logic [31:0] sub_full_s, rcon_word_s, t_s;

  assign wait_done_s = (wait_cnt_r == WAIT_LAST);
  assign last_s      = capture_s && (byte_idx_r == 2'd3);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and per-state strobes
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    issue_s   = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          state_s  = ST_ISSUE;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s = 1'b1;
        if (SBOX_LAT > 1) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_CAPTURE;
        end
      end
      ST_WAIT: begin
        if (wait_done_s) begin
          state_s = ST_CAPTURE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CAPTURE: begin
        capture_s = 1'b1;
        if (byte_idx_r == 2'd3) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // T(w7): merge the byte arriving this cycle, then fold in Rcon
  always_comb begin
    sub_full_s = set_byte(sub_r, byte_idx_r, sbox_out);
    if (use_rcon_r) begin
      rcon_word_s = {rcon_byte(rcon_idx_r), 24'h00_0000};
    end else begin
      rcon_word_s = 32'h0000_0000;
    end
    t_s = sub_full_s ^ rcon_word_s;
  end

  // Operand latch on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w8_r       <= 32'h0000_0000;
      w9_r       <= 32'h0000_0000;
      w10_r      <= 32'h0000_0000;
      w11_r      <= 32'h0000_0000;
      src_r      <= 32'h0000_0000;
      rcon_idx_r <= 3'd0;
      use_rcon_r <= 1'b1;
    end else if (accept_s) begin
      w8_r       <= w8;
      w9_r       <= w9;
      w10_r      <= w10;
      w11_r      <= w11;
      src_r      <= use_rcon_in ? rotword(w7) : w7;
      rcon_idx_r <= rcon_idx_in;
      use_rcon_r <= use_rcon_in;
    end
  end

  // Byte walk: issue to the S-box, wait out its latency, capture result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_r <= 2'd0;
      wait_cnt_r <= 8'd0;
      sub_r      <= 32'h0000_0000;
      sbox_in_r  <= 8'h00;
    end else begin
      if (accept_s) begin
        byte_idx_r <= 2'd0;
      end else if (capture_s && !last_s) begin
        byte_idx_r <= byte_idx_r + 2'd1;
      end
      if (issue_s) begin
        sbox_in_r  <= word_byte(src_r, byte_idx_r);
        wait_cnt_r <= 8'd0;
      end else if (state_r == ST_WAIT) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
      if (capture_s) begin
        sub_r <= sub_full_s;
      end
    end
  end

  // Result, status and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0_r           <= 32'h0000_0000;
      w1_r           <= 32'h0000_0000;
      w2_r           <= 32'h0000_0000;
      w3_r           <= 32'h0000_0000;
      rcon_idx_out_r <= 3'd0;
      use_rcon_out_r <= 1'b1;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      done_r <= last_s;
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (last_s) begin
        busy_r <= 1'b0;
      end
      if (last_s) begin
        w0_r <= w8_r ^ t_s;
        w1_r <= w9_r ^ w8_r;
        w2_r <= w10_r ^ w9_r;
        w3_r <= w11_r ^ w10_r;
        // An i%8==0 quartet is preceded by an i%8==4 one carrying the same
        // index; an i%8==4 quartet by the i%8==0 one with the index below.
        rcon_idx_out_r <= use_rcon_r ? rcon_idx_r : (rcon_idx_r - 3'd1);
        use_rcon_out_r <= ~use_rcon_r;
      end
    end
  end

  assign w0           = w0_r;
  assign w1           = w1_r;
  assign w2           = w2_r;
  assign w3           = w3_r;
  assign rcon_idx_out = rcon_idx_out_r;
  assign use_rcon_out = use_rcon_out_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign sbox_in      = sbox_in_r;

endmodule

// File: tb/tb_invroundkeygen_1lane.sv
// ---------------------------------------------------------------------------
// tb_invroundkeygen_1lane
//   Drives two instances in lockstep: one with a combinational S-box
//   (SBOX_LAT=1) and one with a registered S-box (SBOX_LAT=2). Expected
//   results are queued when a start is issued; a monitor per instance pops
//   and compares when that instance pulses done.
// ---------------------------------------------------------------------------
module tb_invroundkeygen_1lane;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] win [0:7];     // w4..w11
  logic [2:0]  ridx_in;
  logic        use_in;

  logic [31:0] a_w0, a_w1, a_w2, a_w3, b_w0, b_w1, b_w2, b_w3;
  logic [2:0]  a_ridx, b_ridx;
  logic        a_use, b_use, a_busy, b_busy, a_done, b_done;
  logic [7:0]  a_sin, a_sout, b_sin, b_sout;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] w;
    logic [2:0]   ridx;
    logic         use_o;
    logic [31:0]  due;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned done_a   = 0;
  int unsigned done_b   = 0;
  logic [31:0] cyc      = 32'd0;
  logic [31:0] wk [0:59];

  // ---------------- reference S-box (GF(2^8) inverse + affine) -------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
  endfunction

  assign a_sout = sbox_f(a_sin);
  always @(posedge clk) b_sout <= sbox_f(b_sin);

  always @(posedge clk) cyc <= cyc + 32'd1;

  invroundkeygen_1lane #(.SBOX_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .w4(win[0]), .w5(win[1]), .w6(win[2]), .w7(win[3]),
    .w8(win[4]), .w9(win[5]), .w10(win[6]), .w11(win[7]),
    .rcon_idx_in(ridx_in), .use_rcon_in(use_in), .start(start),
    .w0(a_w0), .w1(a_w1), .w2(a_w2), .w3(a_w3),
    .rcon_idx_out(a_ridx), .use_rcon_out(a_use),
    .busy(a_busy), .done(a_done), .sbox_in(a_sin), .sbox_out(a_sout)
  );

  invroundkeygen_1lane #(.SBOX_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .w4(win[0]), .w5(win[1]), .w6(win[2]), .w7(win[3]),
    .w8(win[4]), .w9(win[5]), .w10(win[6]), .w11(win[7]),
    .rcon_idx_in(ridx_in), .use_rcon_in(use_in), .start(start),
    .w0(b_w0), .w1(b_w1), .w2(b_w2), .w3(b_w3),
    .rcon_idx_out(b_ridx), .use_rcon_out(b_use),
    .busy(b_busy), .done(b_done), .sbox_in(b_sin), .sbox_out(b_sout)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic mon(input string tag, input exp_t e, input logic [127:0] words,
                     input logic [2:0] ridx, input logic use_o, input logic busy_o);
    chk({tag, "_words"},   words, e.w);
    chk({tag, "_ridx"},    {125'd0, ridx}, {125'd0, e.ridx});
    chk({tag, "_use"},     {127'd0, use_o}, {127'd0, e.use_o});
    chk({tag, "_latency"}, {96'd0, cyc}, {96'd0, e.due});
    chk({tag, "_busy_at_done"}, {127'd0, busy_o}, 128'd0);
  endtask

  // Monitor, combinational-S-box instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && a_done === 1'b1) begin
      done_a++;
      if (q_a.size() == 0) begin
        chk("a_unexpected_done", {127'd0, a_done}, 128'd0);
      end else begin
        e = q_a.pop_front();
        mon("a", e, {a_w0, a_w1, a_w2, a_w3}, a_ridx, a_use, a_busy);
      end
    end
  end

  // Monitor, registered-S-box instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && b_done === 1'b1) begin
      done_b++;
      if (q_b.size() == 0) begin
        chk("b_unexpected_done", {127'd0, b_done}, 128'd0);
      end else begin
        e = q_b.pop_front();
        mon("b", e, {b_w0, b_w1, b_w2, b_w3}, b_ridx, b_use, b_busy);
      end
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic load(input logic [31:0] a4, a5, a6, a7, a8, a9, a10, a11,
                      input logic u, input logic [2:0] i);
    win[0] = a4; win[1] = a5; win[2] = a6;  win[3] = a7;
    win[4] = a8; win[5] = a9; win[6] = a10; win[7] = a11;
    use_in = u; ridx_in = i;
  endtask

  function automatic logic [127:0] model_words();
    logic [31:0] t;
    if (use_in) t = subword({win[3][23:0], win[3][31:24]}) ^ {8'h01 << ridx_in, 24'h0};
    else        t = subword(win[3]);
    return {win[4] ^ t, win[5] ^ win[4], win[6] ^ win[5], win[7] ^ win[6]};
  endfunction

  // Pulse start for one edge; both instances get the same request.
  task automatic fire(input logic [127:0] ew, input logic [2:0] er, input logic eu);
    @(negedge clk);
    start = 1'b1;
    q_a.push_back('{w: ew, ridx: er, use_o: eu, due: cyc + 32'd9});
    q_b.push_back('{w: ew, ridx: er, use_o: eu, due: cyc + 32'd13});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      chk("done_timeout", {96'd0, 32'(q_a.size() + q_b.size())}, 128'd0);
      q_a.delete();
      q_b.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_words"}, {a_w0, a_w1, a_w2, a_w3}, 128'd0);
    chk({tag, "_b_words"}, {b_w0, b_w1, b_w2, b_w3}, 128'd0);
    chk({tag, "_a_ctl"}, {114'd0, a_ridx, a_use, a_busy, a_done, a_sin},
                         {114'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00});
    chk({tag, "_b_ctl"}, {114'd0, b_ridx, b_use, b_busy, b_done, b_sin},
                         {114'd0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00});
  endtask

  localparam logic [127:0] KEY_LO = {32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
  localparam logic [127:0] KEY_HI = {32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f};

  task automatic load_v1(input logic u, input logic [2:0] i);
    load(32'h10111213, 32'h14151617, 32'h18191a1b, 32'h1c1d1e1f,
         32'ha573c29f, 32'ha176c498, 32'ha97fce93, 32'ha572c09c, u, i);
  endtask

  task automatic load_v2();
    load(32'ha573c29f, 32'ha176c498, 32'ha97fce93, 32'ha572c09c,
         32'h1651a8cd, 32'h0244beda, 32'h1a5da4c1, 32'h0640bade, 1'b0, 3'd1);
  endtask

  // ---------------- directed sequence --------------------------------------
  initial begin
    int unsigned da, db;
    logic [31:0] tmp;
    rst_n = 1'b0;
    start = 1'b0;
    load(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0);
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.3: undo the w8 quartet
    load_v1(1'b1, 3'd0);
    fire(KEY_LO, 3'd0, 1'b0);
    chk("busy_mid_run", {126'd0, a_busy, b_busy}, {126'd0, 2'b11});
    wait_idle();

    // SubWord-only quartet w12..w15
    load_v2();
    fire(KEY_HI, 3'd0, 1'b1);
    wait_idle();

    // Extra starts at edges 2 and 5 with different inputs are ignored
    da = done_a; db = done_b;
    load_v1(1'b1, 3'd0);
    fire(KEY_LO, 3'd0, 1'b0);
    load_v2();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();
    repeat (16) @(negedge clk);
    chk("busy_start_a_one_done", {96'd0, 32'(done_a - da)}, 128'd1);
    chk("busy_start_b_one_done", {96'd0, 32'(done_b - db)}, 128'd1);

    // Rcon index wrap and top Rcon byte
    load_v1(1'b0, 3'd0);
    fire(model_words(), 3'd7, 1'b1);
    wait_idle();
    load_v1(1'b1, 3'd7);
    fire(model_words(), 3'd7, 1'b0);
    wait_idle();

    // Reset asserted before edge 4 of a run
    da = done_a; db = done_b;
    load_v2();
    fire(KEY_HI, 3'd0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    chk_reset("midrun_rst");
    repeat (14) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("rst_no_done", {64'd0, 32'(done_a - da), 32'(done_b - db)}, 128'd0);
    load_v1(1'b1, 3'd0);
    fire(KEY_LO, 3'd0, 1'b0);
    wait_idle();

    // Round trip over a randomly expanded AES-256 key
    for (int i = 0; i < 8; i++) wk[i] = $urandom;
    for (int i = 8; i < 60; i++) begin
      tmp = wk[i-1];
      if (i % 8 == 0) tmp = subword({tmp[23:0], tmp[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
      else if (i % 8 == 4) tmp = subword(tmp);
      wk[i] = wk[i-8] ^ tmp;
    end
    for (int k = 0; k < 13; k++) begin
      int j;
      int q;
      logic eu;
      logic [2:0] ei;
      j = 56 - 4 * k;           // first word of the quartet being undone
      q = j - 4;                // first word of the quartet recovered
      load(wk[j-4], wk[j-3], wk[j-2], wk[j-1], wk[j], wk[j+1], wk[j+2], wk[j+3],
           (j % 8 == 0), (j % 8 == 0) ? 3'(j/8 - 1) : 3'((j + 4)/8 - 1));
      eu = (q % 8 == 0);
      ei = eu ? 3'(q/8 - 1) : 3'((q + 4)/8 - 1);
      fire({wk[q-4], wk[q-3], wk[q-2], wk[q-1]}, ei, eu);
      wait_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
